// File: rtl/pipe_result_fifo.sv
// Result FIFO behind the arithmetic pipe: buffers results until the consumer
// accepts them, flags dropped results, and keeps a running sum of popped values.
module pipe_result_fifo #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [N-1:0]               in_data,
  output logic                       out_valid,
  output logic [N-1:0]               out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf,
  input  logic                       ovf_clr,
  output logic [N+7:0]               acc
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int ACCW = N + 8;

  logic [N-1:0]    r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf;
  logic [ACCW-1:0] r_acc;

  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign w_full = (r_count == CW'(DEPTH));
  assign w_pop  = (r_count != '0) && out_ready;
  assign w_push = in_valid && (!w_full || w_pop);
  assign w_drop = in_valid && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_acc    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_acc    <= r_acc + ACCW'(r_mem[r_rd_ptr]);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // A dropped result wins over a same-cycle clear request.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Storage needs no reset: only occupied entries are ever observed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rd_ptr];
  assign count     = r_count;
  assign ovf       = r_ovf;
  assign acc       = r_acc;

endmodule

// File: tb/tb_pipe_result_fifo.sv
// Scoreboard bench for pipe_result_fifo (N = 8, DEPTH = 4): expected results
// are queued as values are pushed and compared as the DUT pops them.
module tb_pipe_result_fifo;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [2:0]  count;
  logic        ovf;
  logic        ovf_clr;
  logic [15:0] acc;

  logic [7:0]  expQ[$];
  logic [15:0] modelAcc;
  int          passCount;
  int          checkCount;

  pipe_result_fifo #(.N(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .acc       (acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge so outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges and clear the bench model to match.
  task automatic pulseReset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    expQ.delete();
    modelAcc = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; ovf_clr = 1'b0;
    #12;
    checkCount++;
    if ({out_valid, count, ovf, acc} !== {1'b0, 3'd0, 1'b0, 16'd0})
      $display("[TB] FAIL reset_state got valid=%0b count=%0d ovf=%0b acc=%0d want 0/0/0/0", out_valid, count, ovf, acc);
    else passCount++;
    rst_n = 1'b1;
    modelAcc = '0;
  endtask

  task automatic test_single_flow();
    logic [7:0] vals[3] = '{8'd44, 8'd95, 8'd12};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = vals[i]; out_ready = 1'b0;
      tick();
      expQ.push_back(vals[i]);
    end
    in_valid = 1'b0;
    #1;
    checkCount++;
    if (count !== 3'd3 || out_data !== 8'd44)
      $display("[TB] FAIL single_fill got count=%0d data=%0d want 3/44", count, out_data);
    else passCount++;
    for (int i = 0; i < 3; i++) begin
      out_ready = 1'b1;
      #1;
      checkCount++;
      if (!out_valid || out_data !== expQ[0])
        $display("[TB] FAIL single_pop%0d got valid=%0b data=%0d want 1/%0d", i, out_valid, out_data, expQ[0]);
      else passCount++;
      modelAcc += 16'(expQ.pop_front());
      tick();
    end
    out_ready = 1'b0;
    checkCount++;
    if (count !== 3'd0 || out_valid !== 1'b0 || acc !== modelAcc || acc !== 16'd151)
      $display("[TB] FAIL single_end got count=%0d valid=%0b acc=%0d want 0/0/151", count, out_valid, acc);
    else passCount++;
  endtask

  task automatic test_overflow();
    logic expOvf = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      in_valid = 1'b1; in_data = 8'(v); out_ready = 1'b0;
      tick();
      if (expQ.size() < 4) expQ.push_back(8'(v));
      else expOvf = 1'b1;
    end
    in_valid = 1'b0;
    checkCount++;
    if (count !== 3'd4 || ovf !== expOvf || expOvf !== 1'b1)
      $display("[TB] FAIL ovf_fill got count=%0d ovf=%0b want 4/1", count, ovf);
    else passCount++;
    in_valid = 1'b1; in_data = 8'd77; ovf_clr = 1'b1;
    tick();
    in_valid = 1'b0; ovf_clr = 1'b0;
    checkCount++;
    if (ovf !== 1'b1 || count !== 3'd4)
      $display("[TB] FAIL ovf_clr_priority got ovf=%0b count=%0d want 1/4", ovf, count);
    else passCount++;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checkCount++;
    if (ovf !== 1'b0)
      $display("[TB] FAIL ovf_clr got ovf=%0b want 0", ovf);
    else passCount++;
    while (expQ.size() > 0) begin
      out_ready = 1'b1;
      #1;
      checkCount++;
      if (out_data !== expQ[0])
        $display("[TB] FAIL ovf_drain got data=%0d want %0d", out_data, expQ[0]);
      else passCount++;
      modelAcc += 16'(expQ.pop_front());
      tick();
    end
    out_ready = 1'b0;
    checkCount++;
    if (count !== 3'd0 || acc !== modelAcc)
      $display("[TB] FAIL ovf_after got count=%0d acc=%0d want 0/%0d", count, acc, modelAcc);
    else passCount++;
  endtask

  task automatic test_full_push_pop();
    for (int v = 1; v <= 4; v++) begin
      in_valid = 1'b1; in_data = 8'(v); out_ready = 1'b0;
      tick();
      expQ.push_back(8'(v));
    end
    in_valid = 1'b1; in_data = 8'd9; out_ready = 1'b1;
    #1;
    checkCount++;
    if (out_data !== expQ[0])
      $display("[TB] FAIL full_pp_head got data=%0d want %0d", out_data, expQ[0]);
    else passCount++;
    modelAcc += 16'(expQ.pop_front());
    expQ.push_back(8'd9);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    checkCount++;
    if (count !== 3'd4 || ovf !== 1'b0)
      $display("[TB] FAIL full_pp_state got count=%0d ovf=%0b want 4/0", count, ovf);
    else passCount++;
    while (expQ.size() > 0) begin
      out_ready = 1'b1;
      #1;
      checkCount++;
      if (out_data !== expQ[0])
        $display("[TB] FAIL full_pp_drain got data=%0d want %0d", out_data, expQ[0]);
      else passCount++;
      modelAcc += 16'(expQ.pop_front());
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    pulseReset();
    in_valid = 1'b1; in_data = 8'd0; out_ready = 1'b0;
    tick();
    expQ.push_back(8'd0);
    for (int v = 1; v <= 10; v++) begin
      in_valid = (v <= 9); in_data = 8'(v); out_ready = 1'b1;
      #1;
      checkCount++;
      if (count !== 3'd1 || out_data !== expQ[0])
        $display("[TB] FAIL wrap_step%0d got count=%0d data=%0d want 1/%0d", v, count, out_data, expQ[0]);
      else passCount++;
      modelAcc += 16'(expQ.pop_front());
      if (v <= 9) expQ.push_back(8'(v));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checkCount++;
    if (count !== 3'd0 || acc !== modelAcc || acc !== 16'd45)
      $display("[TB] FAIL wrap_acc got count=%0d acc=%0d want 0/45", count, acc);
    else passCount++;
  endtask

  task automatic test_async_reset();
    for (int v = 1; v <= 3; v++) begin
      in_valid = 1'b1; in_data = 8'(v + 20); out_ready = 1'b0;
      tick();
      expQ.push_back(8'(v + 20));
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkCount++;
    if (count !== 3'd0 || out_valid !== 1'b0 || acc !== 16'd0)
      $display("[TB] FAIL async_reset got count=%0d valid=%0b acc=%0d want 0/0/0", count, out_valid, acc);
    else passCount++;
    #2 rst_n = 1'b1;
    expQ.delete();
    modelAcc = '0;
    in_valid = 1'b1; in_data = 8'd7;
    tick();
    expQ.push_back(8'd7);
    in_valid = 1'b0;
    checkCount++;
    if (out_valid !== 1'b1 || count !== 3'd1 || out_data !== expQ[0])
      $display("[TB] FAIL post_reset_push got valid=%0b count=%0d data=%0d want 1/1/7", out_valid, count, out_data);
    else passCount++;
    out_ready = 1'b1;
    modelAcc += 16'(expQ.pop_front());
    tick();
  endtask

  task automatic test_empty_pop();
    out_ready = 1'b1; in_valid = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;
    checkCount++;
    if (count !== 3'd0 || out_valid !== 1'b0 || acc !== modelAcc)
      $display("[TB] FAIL empty_pop got count=%0d valid=%0b acc=%0d want 0/0/%0d", count, out_valid, acc, modelAcc);
    else passCount++;
  endtask

  task automatic test_acc_wrap();
    int badPops = 0;
    pulseReset();
    in_valid = 1'b1; in_data = 8'd255; out_ready = 1'b0;
    tick();
    expQ.push_back(8'd255);
    for (int i = 0; i < 257; i++) begin
      in_valid = (i < 256); in_data = 8'd255; out_ready = 1'b1;
      #1;
      if (out_data !== expQ[0]) badPops++;
      modelAcc += 16'(expQ.pop_front());
      if (i < 256) expQ.push_back(8'd255);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checkCount++;
    if (badPops != 0)
      $display("[TB] FAIL acc_wrap_data got %0d wrong pops want 0", badPops);
    else passCount++;
    checkCount++;
    if (acc !== modelAcc || acc !== 16'd65535 || count !== 3'd0)
      $display("[TB] FAIL acc_wrap got acc=%0d count=%0d want 65535/0", acc, count);
    else passCount++;
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    test_reset();
    test_single_flow();
    test_overflow();
    test_full_push_pop();
    test_wrap();
    test_async_reset();
    test_empty_pop();
    test_acc_wrap();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
